// File: rtl/montgomery_r2_precompute.sv
// Serial modular-doubling generator for the Montgomery constant R^2 mod m, R = 2^NBITS.
// Each completion emits a one-cycle done_irq_p; err flags an even (including zero) modulus.
//
// state  | meaning
// IDLE   | waiting for enable_p; r_red/err hold the last result
// CALC   | one modular doubling per clock, 2*NBITS iterations
// DONE   | single cycle with done_irq_p high
module montgomery_r2_precompute #(
   parameter int NBITS = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_p,
   input  logic [NBITS-1:0] m,
   output logic [NBITS-1:0] r_red,
   output logic             busy,
   output logic             err,
   output logic             done_irq_p
);

   localparam int CW = $clog2(2*NBITS) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(2*NBITS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [NBITS-1:0] r_m_q;
   logic [NBITS-1:0] r_x;
   logic [CW-1:0]    r_cnt;

   logic [NBITS-1:0] w_shl;
   logic             w_ge;
   logic [NBITS-1:0] w_x_next;

   // 2x is NBITS+1 bits wide; its carry-out alone already means 2x >= m.
   // Since x < m, the single subtraction wraps back into range modulo 2^NBITS.
   assign w_shl    = {r_x[NBITS-2:0], 1'b0};
   assign w_ge     = r_x[NBITS-1] | (w_shl >= r_m_q);
   assign w_x_next = w_shl - (w_ge ? r_m_q : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_m_q      <= '0;
         r_x        <= '0;
         r_cnt      <= '0;
         r_red      <= '0;
         busy       <= 1'b0;
         err        <= 1'b0;
         done_irq_p <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (enable_p) begin
                  r_m_q <= m;
                  if (!m[0]) begin
                     err        <= 1'b1;
                     r_red      <= '0;
                     busy       <= 1'b0;
                     done_irq_p <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     busy    <= 1'b1;
                     r_x     <= (m == NBITS'(1)) ? '0 : NBITS'(1);
                     r_cnt   <= '0;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_x   <= w_x_next;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST_ITER) begin
                  r_red      <= w_x_next;
                  err        <= 1'b0;
                  busy       <= 1'b0;
                  done_irq_p <= 1'b1;
                  r_state    <= S_DONE;
               end
            end
            S_DONE: begin
               done_irq_p <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_montgomery_r2_precompute.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, per-DUT monitors pop on done_irq_p.
// Runs an NBITS=8 instance for the directed cases and an NBITS=2048 instance for wide moduli.
module tb_montgomery_r2_precompute;

   localparam int NB = 2048;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en8 = 1'b0;
   logic [7:0]    m8 = '0;
   logic [7:0]    r8;
   logic          busy8, err8, done8;
   logic          en2k = 1'b0;
   logic [NB-1:0] m2k = '0;
   logic [NB-1:0] r2k;
   logic          busy2k, err2k, done2k;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] r;
      logic       e;
      int         start;
      int         lat;
   } exp8_t;

   typedef struct {
      logic [NB-1:0] r;
      logic          e;
      int            start;
      int            lat;
   } exp2k_t;

   exp8_t  q8[$];
   exp2k_t q2k[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   montgomery_r2_precompute #(.NBITS(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .enable_p(en8), .m(m8),
      .r_red(r8), .busy(busy8), .err(err8), .done_irq_p(done8)
   );

   montgomery_r2_precompute #(.NBITS(NB)) u_dut2k (
      .clk(clk), .rst_n(rst_n), .enable_p(en2k), .m(m2k),
      .r_red(r2k), .busy(busy2k), .err(err2k), .done_irq_p(done2k)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // monitor for the 8-bit instance; also counts busy cycles per transaction
   initial begin
      exp8_t e;
      int    bcnt;
      bcnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bcnt = 0;
         end else if (done8) begin
            if (q8.size() == 0) begin
               chk("n8_unexpected_done", 64'(done8), 64'd0);
            end else begin
               e = q8.pop_front();
               chk("n8_r_red", 64'(r8), 64'(e.r));
               chk("n8_err", 64'(err8), 64'(e.e));
               chk("n8_latency", 64'(cyc - e.start), 64'(e.lat));
               chk("n8_busy_cycles", 64'(bcnt), 64'(e.lat - 1));
               chk("n8_busy_at_done", 64'(busy8), 64'd0);
            end
            bcnt = 0;
         end else if (busy8) begin
            bcnt++;
         end
      end
   end

   initial begin
      exp2k_t e;
      forever begin
         @(negedge clk);
         if (rst_n && done2k) begin
            if (q2k.size() == 0) begin
               chk("n2k_unexpected_done", 64'(done2k), 64'd0);
            end else begin
               e = q2k.pop_front();
               chk("n2k_r_red_lo", r2k[63:0], e.r[63:0]);
               chk("n2k_r_red_full", 64'(r2k == e.r), 64'd1);
               chk("n2k_err", 64'(err2k), 64'(e.e));
               chk("n2k_latency", 64'(cyc - e.start), 64'(e.lat));
            end
         end
      end
   end

   task automatic wait_empty8(input int budget);
      for (int i = 0; i < budget && q8.size() != 0; i++) @(negedge clk);
      if (q8.size() != 0) begin
         chk("n8_timeout", 64'(q8.size()), 64'd0);
         q8.delete();
      end
      @(negedge clk);
   endtask

   task automatic wait_empty2k(input int budget);
      for (int i = 0; i < budget && q2k.size() != 0; i++) @(negedge clk);
      if (q2k.size() != 0) begin
         chk("n2k_timeout", 64'(q2k.size()), 64'd0);
         q2k.delete();
      end
      @(negedge clk);
   endtask

   task automatic run8(input logic [7:0] mv, input logic [7:0] er, input logic ee);
      @(negedge clk);
      m8  = mv;
      en8 = 1'b1;
      q8.push_back('{er, ee, cyc, (ee ? 1 : 17)});
      @(negedge clk);
      en8 = 1'b0;
      wait_empty8(40);
   endtask

   task automatic run2k(input logic [NB-1:0] mv, input logic [NB-1:0] er, input logic ee);
      @(negedge clk);
      m2k  = mv;
      en2k = 1'b1;
      q2k.push_back('{er, ee, cyc, (ee ? 1 : 2*NB + 1)});
      @(negedge clk);
      en2k = 1'b0;
      wait_empty2k(2*NB + 20);
   endtask

   initial begin
      logic [NB-1:0] mv;

      repeat (3) @(negedge clk);
      chk("rst_r_red", 64'(r8), 64'd0);
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_err", 64'(err8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_r_red_2k", r2k[63:0], 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: 2^16 mod 251 = 25
      run8(8'hFB, 8'h19, 1'b0);
      // 2: 2^16 mod 255 = 1, mod 1 = 0, mod 3 = 1
      run8(8'hFF, 8'h01, 1'b0);
      run8(8'h01, 8'h00, 1'b0);
      run8(8'h03, 8'h01, 1'b0);
      // 3: even moduli, then recovery
      run8(8'hF0, 8'h00, 1'b1);
      chk("even_busy_after", 64'(busy8), 64'd0);
      run8(8'h00, 8'h00, 1'b1);
      run8(8'hFB, 8'h19, 1'b0);

      // 4: second pulse and new m mid-run are ignored
      @(negedge clk);
      m8  = 8'hFB;
      en8 = 1'b1;
      q8.push_back('{8'h19, 1'b0, cyc, 17});
      @(negedge clk);
      en8 = 1'b0;
      chk("busy_after_accept", 64'(busy8), 64'd1);
      repeat (3) @(negedge clk);
      m8  = 8'h03;
      en8 = 1'b1;
      @(negedge clk);
      en8 = 1'b0;
      wait_empty8(40);
      repeat (20) @(negedge clk);

      // 5: asynchronous reset mid-run, no completion afterwards
      run8(8'h03, 8'h01, 1'b0);
      @(negedge clk);
      m8  = 8'hFB;
      en8 = 1'b1;
      q8.push_back('{8'h19, 1'b0, cyc, 17});
      @(negedge clk);
      en8 = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_r_red", 64'(r8), 64'd0);
      chk("abort_busy", 64'(busy8), 64'd0);
      chk("abort_done", 64'(done8), 64'd0);
      q8.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("post_abort_r_red", 64'(r8), 64'd0);
      run8(8'hFF, 8'h01, 1'b0);

      // 6: wide moduli with closed-form residues
      mv = '1;
      run2k(mv, NB'(1), 1'b0);
      mv = '0;
      mv[NB-1] = 1'b1;
      mv[0] = 1'b1;
      run2k(mv, NB'(4), 1'b0);
      run2k(NB'(3), NB'(1), 1'b0);
      run2k(NB'(1), NB'(0), 1'b0);
      run2k(NB'(2), NB'(0), 1'b1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
